// File: rtl/wb_arbiter_pkg.sv
// Shared widths, the write-back entry type and the arbitration source
// encoding for the write-back arbiter and its load queue.
package wb_arbiter_pkg;

  localparam int REG_ADDR_W   = 5;   // register address width
  localparam int REG_W        = 32;  // register data width
  localparam int REG_NUM      = 32;  // number of architectural registers
  localparam int LQ_DEPTH_DEF = 2;   // default load-queue depth

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_W-1:0]      data;
  } wb_entry_t;

  // Which source owns the write port in the current cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LQ   = 2'd1,
    SRC_MDU  = 2'd2,
    SRC_EX   = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_lq_fifo.sv
// Load-response queue for the write-back arbiter.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_push, i_din     enqueue one {rd, data} entry
//   i_pop             dequeue the head entry
//   o_head            current head entry (valid while !o_empty)
//   o_empty, o_full   occupancy flags
//   o_cnt             number of entries held (0..DEPTH)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The caller never pushes into a full queue nor pops an empty one.
module wb_lq_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = LQ_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  wb_entry_t i_din,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_empty,
  output logic      o_full,
  output logic [AW:0] o_cnt
);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  wb_entry_t   r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_cnt   = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU, mul/div and load results into the single
// register-file write port, buffers non-stallable load responses and keeps
// a per-register busy scoreboard of outstanding loads.
// Ports:
//   clk, rst                                  clock, async active-high reset
//   ex_valid_i/ex_ready_o, ex_rd_i, ex_data_i ALU result handshake
//   mdu_valid_i/mdu_ready_o, mdu_rd_i, mdu_data_i  mul/div result handshake
//   ld_issue_valid_i/ld_issue_ready_o, ld_issue_rd_i  load issue from decode
//   lsu_valid_i, lsu_rd_i, lsu_data_i         load response (no backpressure)
//   we_o, waddr_o, wdata_o                    registered register-file write
//   busy_o                                    bit r: load to xr outstanding
//   err_o                                     sticky unexpected-response flag
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high at the clock edge; a producer holds valid and payload until then, and
// ready never depends on the payload except ld_issue_ready_o on its rd.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int LQ_DEPTH = LQ_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [REG_W-1:0]      ex_data_i,
  input  logic                  mdu_valid_i,
  output logic                  mdu_ready_o,
  input  logic [REG_ADDR_W-1:0] mdu_rd_i,
  input  logic [REG_W-1:0]      mdu_data_i,
  input  logic                  ld_issue_valid_i,
  output logic                  ld_issue_ready_o,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd_i,
  input  logic                  lsu_valid_i,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic [REG_W-1:0]      lsu_data_i,
  output logic                  we_o,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic [REG_NUM-1:0]    busy_o,
  output logic                  err_o
);

  localparam int CW = $clog2(LQ_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);

  logic [CW-1:0]         r_count;
  logic [REG_NUM-1:0]    r_busy;
  logic                  r_err;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [REG_W-1:0]      r_wdata;

  wb_entry_t             w_head;
  wb_entry_t             w_lsu_entry;
  logic                  w_lq_empty;
  logic                  w_lq_full;
  logic [CW-1:0]         w_lq_cnt;
  logic                  w_lq_push;
  logic                  w_lq_pop;
  logic                  w_lsu_legal;
  logic                  w_issue_fire;
  wb_src_e               w_src;
  logic [REG_ADDR_W-1:0] w_win_rd;
  logic [REG_W-1:0]      w_win_data;
  logic [REG_NUM-1:0]    w_busy_nxt;

  assign w_lsu_entry = '{rd: lsu_rd_i, data: lsu_data_i};

  wb_lq_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_lq_push),
    .i_din   (w_lsu_entry),
    .i_pop   (w_lq_pop),
    .o_head  (w_head),
    .o_empty (w_lq_empty),
    .o_full  (w_lq_full),
    .o_cnt   (w_lq_cnt)
  );

  // Load responses cannot wait, so the queue head always wins; mdu and ex
  // only see ready once the queue has drained.
  assign mdu_ready_o      = w_lq_empty;
  assign ex_ready_o       = w_lq_empty && !mdu_valid_i;
  assign ld_issue_ready_o = (r_count < DEPTH_C) &&
                            !((ld_issue_rd_i != '0) && r_busy[ld_issue_rd_i]);
  assign w_issue_fire     = ld_issue_valid_i && ld_issue_ready_o;

  always_comb begin
    w_src      = SRC_NONE;
    w_win_rd   = '0;
    w_win_data = '0;
    if (!w_lq_empty) begin
      w_src      = SRC_LQ;
      w_win_rd   = w_head.rd;
      w_win_data = w_head.data;
    end else if (mdu_valid_i) begin
      w_src      = SRC_MDU;
      w_win_rd   = mdu_rd_i;
      w_win_data = mdu_data_i;
    end else if (ex_valid_i) begin
      w_src      = SRC_EX;
      w_win_rd   = ex_rd_i;
      w_win_data = ex_data_i;
    end
  end

  assign w_lq_pop = (w_src == SRC_LQ);

  // A response is legal only while some issued load has not yet responded,
  // i.e. the outstanding count exceeds what already sits in the queue.
  // That bound also keeps the queue from overflowing.
  assign w_lsu_legal = (r_count > w_lq_cnt);
  assign w_lq_push   = lsu_valid_i && w_lsu_legal && (!w_lq_full || w_lq_pop);

  // WAW stall guarantees the set and clear never target the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_lq_pop)                               w_busy_nxt[w_head.rd]      = 1'b0;
    if (w_issue_fire && (ld_issue_rd_i != '0))  w_busy_nxt[ld_issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_busy  <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      if (w_issue_fire && !w_lq_pop)      r_count <= r_count + 1'b1;
      else if (!w_issue_fire && w_lq_pop) r_count <= r_count - 1'b1;
      r_busy <= w_busy_nxt;
      if (lsu_valid_i && !w_lsu_legal) r_err <= 1'b1;
      // x0 writes still consume the port but are never enabled.
      if (w_src != SRC_NONE) begin
        r_we    <= (w_win_rd != '0);
        r_waddr <= w_win_rd;
        r_wdata <= w_win_data;
      end else begin
        r_we    <= 1'b0;
      end
    end
  end

  assign we_o    = r_we;
  assign waddr_o = r_waddr;
  assign wdata_o = r_wdata;
  assign busy_o  = r_busy;
  assign err_o   = r_err;

endmodule
